crc_frame_ctrl: RTL and testbench

Frame-level sequencer for the bit-serial CRC-CCITT engine (polynomial 0x1021). It accepts a byte stream over a valid/ready handshake and seeds the engine at frame start. It serializes each byte into the engine's enable/init/data_in port, then captures the 16-bit result and holds it until acknowledged. It sits between a byte-wide producer (framer, UART RX, DMA) and the serial CRC engine, which it drives directly.

---
 rtl/crc_pkg.sv | 29 ++
 rtl/crc_word_serializer.sv | 71 +++++++
 rtl/crc_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// crc_pkg
//   Definitions shared by the frame controller, its serializer and the bench.
//   CRC_W / CRC_POLY / CRC_SEED describe the CRC-CCITT engine that is driven
//   by crc_frame_ctrl. crc_step is one serial engine update, and the bench
//   uses it to model the engine.
//   frame_state_t is the frame sequencer state encoding.
package crc_pkg;

  localparam int unsigned      CRC_W    = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_APPEND = 3'd5,
    ST_DONE   = 3'd6
  } frame_state_t;

  // One bit-serial CRC-CCITT update (MSB-first register, data XORed at the top).
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic             d);
    return {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ d) ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc_word_serializer.sv
// crc_word_serializer
//   Holds one input word plus its end-of-frame tag and walks a bit counter
//   from DATA_W-1 down to 0.
//   Ports:
//     clk, reset    rising-edge clock, asynchronous active-low reset
//     load          capture load_data/load_last and restart the counter
//     load_data     word to serialize
//     load_last     word is the final word of its frame
//     advance       step the counter towards 0 (ignored while load is high)
//     bit_next      bit that is current after this edge (lookahead, so the
//                   controller can register it onto the engine data line)
//     last_bit      counter is at 0: the current bit is the word's final one
//     word_last     end-of-frame tag of the held word
//   Parameters: DATA_W word width; MSB_FIRST 1 = bit DATA_W-1 first.
module crc_word_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              advance,
  output logic              bit_next,
  output logic              last_bit,
  output logic              word_last
);

  localparam int unsigned      CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  idx;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (load) begin
      word_d = load_data;
      cnt_d  = CNT_MAX;
      last_d = load_last;
    end else if (advance && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    idx = MSB_FIRST ? cnt_d : (CNT_MAX - cnt_d);
  end

  assign bit_next  = word_d[idx];
  assign last_bit  = (cnt_q == '0);
  assign word_last = last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl
//   Frame sequencer for a bit-serial CRC-CCITT engine. Accepts words over a
//   valid/ready handshake, seeds the engine at frame start, serializes each
//   word into the engine, then captures and holds the 16-bit result until it
//   is acknowledged.
//   Ports:
//     clk, reset              rising-edge clock, asynchronous active-low reset
//     s_valid/s_ready/s_data  input word handshake (s_ready is combinational)
//     s_last                  marks the final word of a frame
//     crc_enable/crc_init/crc_data   registered engine controls
//     crc_in                  engine CRC output
//     crc_valid/crc_value     registered frame CRC, held until crc_ack
//     crc_ack                 consumer takes crc_value (only honoured in DONE)
//     busy                    high whenever not IDLE
//     tx_bit/tx_valid         serial frame+CRC stream (only with CRC_APPEND_EN)
//   Build option: define CRC_APPEND_EN to add the APPEND state and tx_* ports.
module crc_frame_ctrl
  import crc_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              crc_enable,
  output logic              crc_init,
  output logic              crc_data,
  input  logic [CRC_W-1:0]  crc_in,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_value,
  input  logic              crc_ack,
  output logic              busy
`ifdef CRC_APPEND_EN
  ,
  output logic              tx_bit,
  output logic              tx_valid
`endif
);

  frame_state_t state_q, state_d;
  logic         ser_load;
  logic         ser_adv;
  logic         ser_bit;
  logic         last_bit;
  logic         word_last;

`ifdef CRC_APPEND_EN
  localparam int unsigned APP_W = $clog2(CRC_W);
  logic [APP_W-1:0] app_cnt;
  logic [APP_W-1:0] app_nxt;
  assign app_nxt = app_cnt - APP_W'(1);
`endif

  crc_word_serializer #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_data (s_data),
    .load_last (s_last),
    .advance   (ser_adv),
    .bit_next  (ser_bit),
    .last_bit  (last_bit),
    .word_last (word_last)
  );

  // Next-state and handshake decode. Outputs below are registered from
  // state_d so each one is valid during the cycle of the state it belongs to.
  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    ser_adv  = 1'b0;
    s_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ser_load = 1'b1;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (!last_bit) begin
          ser_adv = 1'b1;
        end else if (word_last) begin
          state_d = ST_WAIT;
        end else begin
          // Accepting on the final bit keeps the engine fed with no bubble.
          s_ready = 1'b1;
          if (s_valid) ser_load = 1'b1;
          else         state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
`ifdef CRC_APPEND_EN
      ST_WAIT:   state_d = ST_APPEND;
      ST_APPEND: if (app_cnt == '0) state_d = ST_DONE;
`else
      ST_WAIT:   state_d = ST_DONE;
      ST_APPEND: state_d = ST_DONE;
`endif
      ST_DONE:   if (crc_ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      crc_enable <= 1'b0;
      crc_init   <= 1'b0;
      crc_data   <= 1'b0;
      crc_valid  <= 1'b0;
      crc_value  <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_enable <= (state_d == ST_INIT) || (state_d == ST_SHIFT);
      crc_init   <= (state_d == ST_INIT);
      crc_data   <= (state_d == ST_SHIFT) && ser_bit;
      crc_valid  <= (state_d == ST_DONE);
      busy       <= (state_d != ST_IDLE);
      // Engine output settles one cycle after the last shift, i.e. in WAIT.
      if (state_q == ST_WAIT) crc_value <= crc_in;
    end
  end

`ifdef CRC_APPEND_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      app_cnt  <= '0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= (state_d == ST_SHIFT) || (state_d == ST_APPEND);
      if (state_q == ST_WAIT)        app_cnt <= APP_W'(CRC_W - 1);
      else if (state_q == ST_APPEND) app_cnt <= app_nxt;
      // crc_value is loaded on the same edge APPEND starts, so its MSB is
      // taken straight from crc_in for the first appended bit.
      if (state_d == ST_SHIFT)        tx_bit <= ser_bit;
      else if (state_q == ST_WAIT)    tx_bit <= crc_in[CRC_W-1];
      else if (state_d == ST_APPEND)  tx_bit <= crc_value[app_nxt];
      else                            tx_bit <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_crc_frame_ctrl.sv
module tb_crc_frame_ctrl;
  import crc_pkg::*;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        crc_enable;
  logic        crc_init;
  logic        crc_data;
  logic [15:0] crc_in;
  logic        crc_valid;
  logic [15:0] crc_value;
  logic        crc_ack;
  logic        busy;
`ifdef CRC_APPEND_EN
  logic        tx_bit;
  logic        tx_valid;
`endif

  int n_cmp;
  int n_bad;

  crc_frame_ctrl #(
    .DATA_W    (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .crc_enable (crc_enable),
    .crc_init   (crc_init),
    .crc_data   (crc_data),
    .crc_in     (crc_in),
    .crc_valid  (crc_valid),
    .crc_value  (crc_value),
    .crc_ack    (crc_ack),
    .busy       (busy)
`ifdef CRC_APPEND_EN
    ,
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial CRC-CCITT engine: updates on the edge it samples enable.
  logic [15:0] eng;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          eng <= '0;
    else if (crc_enable) eng <= crc_init ? CRC_SEED : crc_step(eng, crc_data);
  end
  assign crc_in = eng;

  // Free-running observers; tests take before/after snapshots.
  int edge_n;
  int init_total;
  int hold_total;
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(negedge clk) begin
    if (crc_init === 1'b1) init_total <= init_total + 1;
    if (busy === 1'b1 && s_ready === 1'b1 && crc_enable === 1'b0)
      hold_total <= hold_total + 1;
  end
`ifdef CRC_APPEND_EN
  int          tx_total;
  logic [23:0] tx_vec;
  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      tx_total <= tx_total + 1;
      tx_vec   <= {tx_vec[22:0], tx_bit};
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a word at a falling edge and hold it until accepted. Returns the
  // number of the accepting rising edge; returns at the next falling edge.
  task automatic put_word(input logic [7:0] d, input logic last, output int acc);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: s_ready=%b after %0d cycles, required 1", s_ready, t);
    end
    acc = edge_n + 1;
    @(negedge clk);
  endtask

  task automatic wait_valid(output int e);
    int t;
    t = 0;
    while (crc_valid !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_timeout: crc_valid=%b after %0d cycles, required 1", crc_valid, t);
    end
    e = edge_n;
  endtask

  task automatic do_ack;
    crc_ack = 1'b1;
    @(negedge clk);
    crc_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; crc_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    n_cmp++; if (crc_enable !== 1'b0) begin n_bad++; $display("FAIL rst_crc_enable: got %b want 0", crc_enable); end
    n_cmp++; if (crc_init !== 1'b0) begin n_bad++; $display("FAIL rst_crc_init: got %b want 0", crc_init); end
    n_cmp++; if (crc_data !== 1'b0) begin n_bad++; $display("FAIL rst_crc_data: got %b want 0", crc_data); end
    n_cmp++; if (crc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_crc_valid: got %b want 0", crc_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (crc_value !== 16'h0000) begin n_bad++; $display("FAIL rst_crc_value: got %h want 0000", crc_value); end
`ifdef CRC_APPEND_EN
    n_cmp++; if ({tx_bit, tx_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_tx: got %b want 00", {tx_bit, tx_valid}); end
`endif
    reset = 1'b1;
    // Ack outside DONE must be ignored.
    crc_ack = 1'b1;
    repeat (2) @(negedge clk);
    crc_ack = 1'b0;
    n_cmp++; if (busy !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ack_ignored: busy=%b s_ready=%b want 0/1", busy, s_ready); end
  endtask

  task automatic test_single_word;
    int acc, e, i0;
    i0 = init_total;
    put_word(8'h41, 1'b1, acc);
    s_valid = 1'b0;
    wait_valid(e);
    n_cmp++; if (e !== acc + 10) begin n_bad++; $display("FAIL single_latency: valid after edge %0d want %0d", e - acc, 10); end
    n_cmp++; if (crc_value !== 16'hB915) begin n_bad++; $display("FAIL single_crc: got %h want b915", crc_value); end
    n_cmp++; if (init_total - i0 !== 1) begin n_bad++; $display("FAIL single_init_cycles: got %0d want 1", init_total - i0); end
    do_ack();
    n_cmp++; if (crc_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_ack_idle: valid=%b busy=%b want 0/0", crc_valid, busy); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL single_ack_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_back_to_back;
    int acc0, acc, e, h0;
    logic [7:0] w;
    h0 = hold_total;
    acc0 = 0;
    for (int i = 0; i < 9; i++) begin
      w = 8'h31 + 8'(i);
      put_word(w, (i == 8), acc);
      if (i == 0) acc0 = acc;
    end
    s_valid = 1'b0;
    wait_valid(e);
    n_cmp++; if (e !== acc0 + 74) begin n_bad++; $display("FAIL b2b_latency: valid after edge %0d want %0d", e - acc0, 74); end
    n_cmp++; if (crc_value !== 16'h29B1) begin n_bad++; $display("FAIL b2b_crc: got %h want 29b1", crc_value); end
    n_cmp++; if (hold_total - h0 !== 0) begin n_bad++; $display("FAIL b2b_hold_cycles: got %0d want 0", hold_total - h0); end
    do_ack();
  endtask

  task automatic test_gap_hold;
    int acc0, acc, e, h0, t;
    h0 = hold_total;
    put_word(8'h41, 1'b0, acc0);
    s_valid = 1'b0;
    t = 0;
    while (s_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    crc_ack = 1'b1;
    repeat (5) @(negedge clk);
    crc_ack = 1'b0;
    n_cmp++; if (busy !== 1'b1 || s_ready !== 1'b1 || crc_enable !== 1'b0) begin n_bad++; $display("FAIL gap_in_hold: busy=%b s_ready=%b en=%b want 1/1/0", busy, s_ready, crc_enable); end
    put_word(8'h00, 1'b1, acc);
    s_valid = 1'b0;
    wait_valid(e);
    n_cmp++; if (hold_total - h0 !== 5) begin n_bad++; $display("FAIL gap_hold_cycles: got %0d want 5", hold_total - h0); end
    n_cmp++; if (e !== acc0 + 23) begin n_bad++; $display("FAIL gap_latency: valid after edge %0d want %0d", e - acc0, 23); end
    n_cmp++; if (crc_value !== 16'h23F2) begin n_bad++; $display("FAIL gap_crc: got %h want 23f2", crc_value); end
    do_ack();
  endtask

  task automatic test_ack_withheld;
    int acc, e, i0;
    put_word(8'h41, 1'b1, acc);
    s_valid = 1'b0;
    wait_valid(e);
    // Offer another word while DONE; it must not be taken.
    s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1;
    for (int c = 0; c < 20; c++) begin
      n_cmp++; if (crc_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want 1", c, crc_valid); end
      n_cmp++; if (crc_value !== 16'hB915) begin n_bad++; $display("FAIL hold_value[%0d]: got %h want b915", c, crc_value); end
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b want 0", c, s_ready); end
      @(negedge clk);
    end
    s_valid = 1'b0;
    do_ack();
    n_cmp++; if (busy !== 1'b0 || crc_valid !== 1'b0) begin n_bad++; $display("FAIL late_ack_idle: busy=%b valid=%b want 0/0", busy, crc_valid); end
    i0 = init_total;
    put_word(8'h00, 1'b1, acc);
    wait_valid(e);
    s_valid = 1'b0;
    n_cmp++; if (crc_value !== 16'hE1F0) begin n_bad++; $display("FAIL second_frame_crc: got %h want e1f0", crc_value); end
    n_cmp++; if (init_total - i0 !== 1) begin n_bad++; $display("FAIL second_frame_init: got %0d want 1", init_total - i0); end
    do_ack();
  endtask

  task automatic test_reset_mid_frame;
    int acc, e;
    put_word(8'h31, 1'b0, acc);
    put_word(8'h32, 1'b0, acc);
    put_word(8'h33, 1'b0, acc);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (crc_enable !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_shift: en=%b busy=%b want 1/1", crc_enable, busy); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({s_ready, crc_enable, crc_init, crc_data, crc_valid, busy} !== 6'b100000)
      begin n_bad++; $display("FAIL mid_reset_outputs: got %b want 100000", {s_ready, crc_enable, crc_init, crc_data, crc_valid, busy}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    put_word(8'h41, 1'b1, acc);
    s_valid = 1'b0;
    wait_valid(e);
    n_cmp++; if (crc_value !== 16'hB915) begin n_bad++; $display("FAIL post_reset_crc: got %h want b915", crc_value); end
    n_cmp++; if (e !== acc + 10) begin n_bad++; $display("FAIL post_reset_latency: valid after edge %0d want %0d", e - acc, 10); end
    do_ack();
  endtask

`ifdef CRC_APPEND_EN
  task automatic test_append;
    int acc, e, t0;
    t0 = tx_total;
    put_word(8'h41, 1'b1, acc);
    s_valid = 1'b0;
    wait_valid(e);
    n_cmp++; if (tx_total - t0 !== 24) begin n_bad++; $display("FAIL append_tx_cycles: got %0d want 24", tx_total - t0); end
    n_cmp++; if (tx_vec !== 24'h41B915) begin n_bad++; $display("FAIL append_tx_bits: got %h want 41b915", tx_vec); end
    n_cmp++; if (e !== acc + 26) begin n_bad++; $display("FAIL append_latency: valid after edge %0d want %0d", e - acc, 26); end
    do_ack();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap_hold();
    test_ack_withheld();
    test_reset_mid_frame();
`ifdef CRC_APPEND_EN
    test_append();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
